// File: rtl/uart_tx_frame_scheduler_pkg.sv
// Shared definitions for the UART TX frame scheduler.
//  - Default frame geometry and framing byte.
//  - FSM state encoding (3-bit).
//  - Byte-index width helper: wide enough to count 0..frame_bytes inclusive,
//    where index == frame_bytes selects the terminator.
package uart_tx_frame_scheduler_pkg;

  localparam int              DEF_PAYLOAD_BITS = 8;
  localparam int              DEF_FRAME_BYTES  = 3;
  localparam logic [7:0]      DEF_TERMINATOR   = 8'h0A;
  localparam int              DEF_BUSY_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4
  } state_t;

  function automatic int idx_width(input int frame_bytes);
    return $clog2(frame_bytes + 1);
  endfunction

endpackage

// File: rtl/uart_tx_frame_scheduler_if.sv
// Bus bundle between the two frame sources, the scheduler and the uart_tx.
//  req0_* / req1_*  : frame offer (valid + data) and 1-cycle accept pulse
//  uart_tx_*        : start pulse, byte and busy flag of the shared transmitter
//  owner/active     : source of the frame in flight, frame-in-flight flag
//  frame_done       : 1-cycle pulse after the terminator completes
//  retry_err        : sticky busy-timeout flag
// Modports:
//  master : environment side (sources + transmitter)
//  slave  : the scheduler
interface uart_tx_frame_scheduler_if
  import uart_tx_frame_scheduler_pkg::*;
#(
  parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
  parameter int FRAME_BYTES  = DEF_FRAME_BYTES
);

  logic                                  req0_valid;
  logic [FRAME_BYTES*PAYLOAD_BITS-1:0]   req0_data;
  logic                                  req0_ready;
  logic                                  req1_valid;
  logic [FRAME_BYTES*PAYLOAD_BITS-1:0]   req1_data;
  logic                                  req1_ready;
  logic                                  uart_tx_en;
  logic [PAYLOAD_BITS-1:0]               uart_tx_data;
  logic                                  uart_tx_busy;
  logic                                  owner;
  logic                                  active;
  logic                                  frame_done;
  logic                                  retry_err;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, uart_tx_busy,
    input  req0_ready, req1_ready, uart_tx_en, uart_tx_data,
           owner, active, frame_done, retry_err
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, uart_tx_busy,
    output req0_ready, req1_ready, uart_tx_en, uart_tx_data,
           owner, active, frame_done, retry_err
  );

endinterface

// File: rtl/uart_tx_frame_scheduler_rr_arb2.sv
// Two-request round-robin arbiter (purely combinational).
//  req[1:0]    : request lines
//  last_grant  : index of the most recently served requester
//  grant[1:0]  : one-hot grant, zero when nothing requests
// A lone request always wins; on a tie the requester that was not served
// last wins. Reusable for the RX side.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // NOTE: combinational blocks assign every output a default first, so no
  // path through the case can leave a value held (which would infer a latch).
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/uart_tx_frame_scheduler.sv
// Shares one uart_tx between two frame sources (req0 telemetry, req1 command
// echo). An accepted frame is sent as FRAME_BYTES payload bytes, MSB byte
// first, followed by TERMINATOR. Frames are never interleaved.
// Ports:
//  i_clk     : system clock
//  i_resetn  : asynchronous active-low reset; abandons any frame in flight
//  bus       : slave side of uart_tx_frame_scheduler_if (sources, uart_tx,
//              status flags)
module uart_tx_frame_scheduler
  import uart_tx_frame_scheduler_pkg::*;
#(
  parameter int                      PAYLOAD_BITS = DEF_PAYLOAD_BITS,
  parameter int                      FRAME_BYTES  = DEF_FRAME_BYTES,
  parameter logic [PAYLOAD_BITS-1:0] TERMINATOR   = PAYLOAD_BITS'(DEF_TERMINATOR),
  parameter int                      BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                       i_clk,
  input  logic                       i_resetn,
  uart_tx_frame_scheduler_if.slave   bus
);

  localparam int IDX_W   = idx_width(FRAME_BYTES);
  localparam int CNT_W   = $clog2(BUSY_TIMEOUT + 1);
  localparam int FRAME_W = FRAME_BYTES * PAYLOAD_BITS;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  state_t                  state, state_next;
  logic [IDX_W-1:0]        idx;
  logic [FRAME_W-1:0]      shadow;
  logic                    owner;
  logic                    last_grant;
  logic [CNT_W-1:0]        tmo_cnt;
  logic                    retry_err;
  logic                    frame_done;
  logic [1:0]              grant;
  logic [PAYLOAD_BITS-1:0] cur_byte;
  logic                    in_frame;

  // FSM strobes
  logic take_req;    // IDLE -> GRANT: remember the winner
  logic load_frame;  // GRANT: capture frame into shadow
  logic start_byte;  // SEND: the en pulse itself
  logic next_byte;   // WAIT_LO done, more bytes to go
  logic retry;       // WAIT_HI timed out
  logic finish;      // terminator completed

  rr_arb2 u_arb (
    .req        ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    state_next = state;
    take_req   = 1'b0;
    load_frame = 1'b0;
    start_byte = 1'b0;
    next_byte  = 1'b0;
    retry      = 1'b0;
    finish     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (grant != 2'b00 && !bus.uart_tx_busy) begin
          take_req   = 1'b1;
          state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        load_frame = 1'b1;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        // Hold the pulse back if the transmitter is still busy, so en is
        // never raised on top of busy.
        if (!bus.uart_tx_busy) begin
          start_byte = 1'b1;
          state_next = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (bus.uart_tx_busy) begin
          state_next = ST_WAIT_LO;
        end else if (tmo_cnt == TMO_LAST) begin
          retry      = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_WAIT_LO: begin
        if (!bus.uart_tx_busy) begin
          if (idx == LAST_IDX) begin
            finish     = 1'b1;
            state_next = ST_IDLE;
          end else begin
            next_byte  = 1'b1;
            state_next = ST_SEND;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) state <= ST_IDLE;
    else           state <= state_next;
  end

  // NOTE: the shadow register is reset as well; it is only a few flops and
  // keeps uart_tx_data at zero out of reset without relying on gating alone.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      idx        <= '0;
      shadow     <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;   // req0 wins the first tie
      tmo_cnt    <= '0;
      retry_err  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= finish;
      if (take_req)   owner <= grant[1];
      if (load_frame) begin
        shadow <= owner ? bus.req1_data : bus.req0_data;
        idx    <= '0;
      end
      if (next_byte)  idx <= idx + IDX_W'(1);
      if (start_byte)              tmo_cnt <= '0;
      else if (state == ST_WAIT_HI) tmo_cnt <= tmo_cnt + CNT_W'(1);
      if (retry)      retry_err  <= 1'b1;
      if (finish)     last_grant <= owner;
    end
  end

  // Byte mux: index 0 is the most significant payload byte; the index one
  // past the payload selects the terminator.
  always_comb begin
    cur_byte = TERMINATOR;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      if (idx == IDX_W'(i)) cur_byte = shadow[(FRAME_BYTES-1-i)*PAYLOAD_BITS +: PAYLOAD_BITS];
    end
  end

  assign in_frame = (state == ST_SEND) || (state == ST_WAIT_HI) || (state == ST_WAIT_LO);

  assign bus.uart_tx_en   = start_byte;
  assign bus.uart_tx_data = in_frame ? cur_byte : '0;
  assign bus.req0_ready   = (state == ST_GRANT) && !owner;
  assign bus.req1_ready   = (state == ST_GRANT) &&  owner;
  assign bus.owner        = owner;
  assign bus.active       = (state != ST_IDLE);
  assign bus.frame_done   = frame_done;
  assign bus.retry_err    = retry_err;

endmodule

// File: tb/tb_uart_tx_frame_scheduler.sv
// Self-checking bench for uart_tx_frame_scheduler: directed frame table,
// multi-cycle corner sequences, and randomized traffic against a reference.
module tb_uart_tx_frame_scheduler;

  localparam int PB = 8;
  localparam int FB = 3;
  localparam int FW = PB * FB;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_frame_scheduler_if #(.PAYLOAD_BITS(PB), .FRAME_BYTES(FB)) bus ();

  uart_tx_frame_scheduler #(
    .PAYLOAD_BITS (PB),
    .FRAME_BYTES  (FB),
    .TERMINATOR   (8'h0A),
    .BUSY_TIMEOUT (TO)
  ) dut (
    .i_clk    (clk),
    .i_resetn (rst_n),
    .bus      (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- transmitter model ----------------
  logic [7:0] sent[$];
  int         en_cyc[$];
  int         busy_len  = 10;
  bit         rand_busy = 0;
  bit         drop_pending = 0;
  int         drop_at = 0;
  int         acc_n = 0;
  logic [7:0] dropped_byte = '0;
  int         drop_cyc = 0;

  initial begin
    int bl;
    bus.uart_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.uart_tx_en === 1'b1) begin
        en_cyc.push_back(cyc);
        if (drop_pending && acc_n == drop_at) begin
          drop_pending = 0;
          dropped_byte = bus.uart_tx_data;
          drop_cyc     = cyc;
        end else begin
          sent.push_back(bus.uart_tx_data);
          acc_n++;
          bl = rand_busy ? int'($urandom_range(1, 12)) : busy_len;
          @(posedge clk); #1 bus.uart_tx_busy = 1'b1;
          repeat (bl) @(posedge clk);
          #1 bus.uart_tx_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- reference arbiter + scoreboard ----------------
  logic [7:0] exp_q[$];
  bit         winners[$];
  bit         pv0 = 0, pv1 = 0;
  bit         ref_last = 1;
  int         ready_cnt = 0;
  int         done_cnt  = 0;

  // valids as seen by the DUT at the decision edge
  always @(posedge clk) begin
    pv0 = bus.req0_valid;
    pv1 = bus.req1_valid;
  end

  initial begin
    bit         w, ew;
    logic [FW-1:0] d;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ref_last = 1;
      end else begin
        if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) begin
          w  = (bus.req1_ready === 1'b1);
          ew = (pv0 && pv1) ? !ref_last : pv1;
          check("arb_winner", 32'(w), 32'(ew));
          check("owner_at_grant", 32'(bus.owner), 32'(w));
          ref_last = w;
          winners.push_back(w);
          ready_cnt++;
          d = w ? bus.req1_data : bus.req0_data;
          for (int k = 0; k < FB; k++) exp_q.push_back(8'(d >> (8 * (FB - 1 - k))));
          exp_q.push_back(8'h0A);
        end
        if (bus.frame_done === 1'b1) begin
          done_cnt++;
          check("active_low_at_done", 32'(bus.active), 32'd0);
        end
      end
    end
  end

  // ---------------- protocol monitor ----------------
  int         viol = 0;
  bit         prev_en = 0;
  logic [7:0] last_en_data = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.uart_tx_en === 1'b1 && bus.uart_tx_busy === 1'b1) viol++;
        if (bus.uart_tx_en === 1'b1 && prev_en) viol++;
        if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) viol++;
        if (bus.active === 1'b1 && bus.uart_tx_busy === 1'b1 && bus.uart_tx_en !== 1'b1
            && bus.uart_tx_data !== last_en_data) viol++;
        if (bus.uart_tx_en === 1'b1) last_en_data = bus.uart_tx_data;
      end
      prev_en = (bus.uart_tx_en === 1'b1);
    end
  end

  // ---------------- helpers ----------------
  task automatic send_req(input bit src, input logic [FW-1:0] data, output int lat);
    int n;
    bit got;
    lat = -1;
    got = 0;
    @(negedge clk);
    if (src) begin bus.req1_data = data; bus.req1_valid = 1'b1; end
    else     begin bus.req0_data = data; bus.req0_valid = 1'b1; end
    n = 0;
    while (!got && n < 1000) begin
      @(negedge clk);
      n++;
      if ((src ? bus.req1_ready : bus.req0_ready) === 1'b1) got = 1;
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
    else      lat = n;
    @(posedge clk); #1;
    if (src) bus.req1_valid = 1'b0;
    else     bus.req0_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_reached", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic check_sent(input string name, input logic [63:0] pk, input int nb);
    int         mism = 0;
    logic [7:0] b;
    check({name, "_len"}, 32'(sent.size()), 32'(nb));
    for (int k = 0; k < nb; k++) begin
      b = 8'(pk >> (8 * (nb - 1 - k)));
      if (k >= sent.size() || sent[k] !== b) mism++;
    end
    check({name, "_bytes"}, 32'(mism), 32'd0);
  endtask

  task automatic clear_logs();
    sent.delete();
    exp_q.delete();
    winners.delete();
    en_cyc.delete();
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while (bus.uart_tx_busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  typedef struct {
    bit            src;
    logic [FW-1:0] data;
    logic [31:0]   exp_bytes;
  } vec_t;

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t          vecs[4];
    int            lat_a, lat_b, d0, r0, gap, n;
    logic [FW-1:0] rd;

    vecs[0] = '{src: 1'b0, data: 24'h140000, exp_bytes: 32'h1400000A};
    vecs[1] = '{src: 1'b1, data: 24'hD4E5F6, exp_bytes: 32'hD4E5F60A};
    vecs[2] = '{src: 1'b0, data: 24'hFFFFFF, exp_bytes: 32'hFFFFFF0A};
    vecs[3] = '{src: 1'b1, data: 24'h00000A, exp_bytes: 32'h00000A0A};

    bus.req0_valid = 1'b0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0;

    // reset state
    #23;
    check("reset_outputs", 32'({bus.req0_ready, bus.req1_ready, bus.uart_tx_en, bus.uart_tx_data,
                                bus.owner, bus.active, bus.frame_done, bus.retry_err}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'({bus.active, bus.uart_tx_en, bus.req0_ready, bus.req1_ready}), 32'd0);

    // table-driven single frames
    for (int i = 0; i < 4; i++) begin
      clear_logs();
      wait_tx_idle();
      d0 = done_cnt;
      send_req(vecs[i].src, vecs[i].data, lat_a);
      check("ready_latency", 32'(lat_a), 32'd1);
      @(negedge clk);
      check("first_en_latency", 32'(bus.uart_tx_en), 32'd1);
      check("first_byte", 32'(bus.uart_tx_data), 32'(vecs[i].exp_bytes[31:24]));
      wait_done(d0 + 1);
      repeat (3) @(negedge clk);
      check("one_done_per_frame", 32'(done_cnt - d0), 32'd1);
      check_sent("vec_frame", 64'(vecs[i].exp_bytes), 4);
      check("vec_owner", 32'(winners.size() > 0 ? winners[0] : 1'bx), 32'(vecs[i].src));
    end

    // simultaneous requests: req0 first, no interleave
    clear_logs();
    wait_tx_idle();
    d0 = done_cnt;
    fork
      send_req(1'b0, 24'hA1B2C3, lat_a);
      send_req(1'b1, 24'hD4E5F6, lat_b);
    join
    wait_done(d0 + 2);
    check_sent("tie_frames", 64'hA1B2C30AD4E5F60A, 8);
    check("tie_first_owner", 32'(winners.size() > 0 ? winners[0] : 1'bx), 32'd0);

    // both held for four frames: strict alternation
    clear_logs();
    wait_tx_idle();
    d0 = done_cnt;
    r0 = ready_cnt;
    fork
      begin repeat (2) send_req(1'b0, 24'($urandom), lat_a); end
      begin repeat (2) send_req(1'b1, 24'($urandom), lat_b); end
    join
    wait_done(d0 + 4);
    check("rr_ready_count", 32'(ready_cnt - r0), 32'd4);
    check("rr_owner_seq", 32'({winners.size() > 0 ? winners[0] : 1'bx, winners.size() > 1 ? winners[1] : 1'bx,
                               winners.size() > 2 ? winners[2] : 1'bx, winners.size() > 3 ? winners[3] : 1'bx}),
          32'b0101);
    n = 0;
    for (int k = 0; k < exp_q.size(); k++) if (k >= sent.size() || sent[k] !== exp_q[k]) n++;
    check("rr_bytes", 32'(n), 32'd0);

    // transmitter ignores the first en of byte 1 -> timeout retry
    clear_logs();
    wait_tx_idle();
    check("retry_err_clear", 32'(bus.retry_err), 32'd0);
    d0 = done_cnt;
    acc_n = 0; drop_at = 1; drop_pending = 1;
    send_req(1'b0, 24'h5A3C96, lat_a);
    wait_done(d0 + 1);
    check("retry_err_set", 32'(bus.retry_err), 32'd1);
    check("dropped_byte", 32'(dropped_byte), 32'h3C);
    gap = -1;
    foreach (en_cyc[k]) if (gap < 0 && en_cyc[k] > drop_cyc) gap = en_cyc[k] - drop_cyc;
    check("retry_gap", 32'(gap), 32'(TO + 1));
    check_sent("retry_frame", 64'h5A3C960A, 4);

    // reset in the middle of byte 2
    clear_logs();
    wait_tx_idle();
    send_req(1'b0, 24'h112233, lat_a);
    n = 0;
    while (sent.size() < 3 && n < 500) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("pre_reset_active", 32'(bus.active), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_async_drop", 32'({bus.uart_tx_en, bus.uart_tx_data, bus.active, bus.retry_err}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    d0 = done_cnt;
    fork
      send_req(1'b0, 24'h778899, lat_a);
      send_req(1'b1, 24'hAABBCC, lat_b);
    join
    wait_done(d0 + 2);
    repeat (3) @(negedge clk);
    check("post_reset_first_owner", 32'(winners.size() > 0 ? winners[0] : 1'bx), 32'd0);
    check("post_reset_done_count", 32'(done_cnt - d0), 32'd2);
    check_sent("post_reset_frames", 64'h7788990AAABBCC0A, 8);

    // data change after ready does not affect the frame
    clear_logs();
    wait_tx_idle();
    d0 = done_cnt;
    send_req(1'b0, 24'hC0FFEE, lat_a);
    n = 0;
    while (sent.size() < 1 && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    bus.req0_data = 24'h123456;
    wait_done(d0 + 1);
    check_sent("latched_data", 64'hC0FFEE0A, 4);

    // randomized traffic against the scoreboard
    clear_logs();
    wait_tx_idle();
    rand_busy = 1;
    d0 = done_cnt;
    r0 = ready_cnt;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(0, 30)) @(negedge clk);
          send_req(1'b0, 24'($urandom), lat_a);
        end
      end
      begin
        for (int j = 0; j < 12; j++) begin
          repeat ($urandom_range(0, 30)) @(negedge clk);
          rd = 24'($urandom);
          send_req(1'b1, rd, lat_b);
        end
      end
    join
    wait_done(d0 + 24);
    check("rand_ready_count", 32'(ready_cnt - r0), 32'd24);
    check("rand_byte_count", 32'(sent.size()), 32'(exp_q.size()));
    n = 0;
    for (int k = 0; k < exp_q.size(); k++) if (k >= sent.size() || sent[k] !== exp_q[k]) n++;
    check("rand_bytes", 32'(n), 32'd0);

    check("protocol_violations", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
